// File: rtl/div_pkg.sv
// Shared definitions for the 8-bit sequential restoring divider.
// Optional build macro used by the divider: DIV_ZERO_SHORTCUT_EN.
`timescale 1ns/1ps
package div_pkg;

  localparam int DIV_W      = 8;
  localparam int ITER_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step:
// 9-bit partial remainder minus 8-bit divisor, with borrow-out.
`timescale 1ns/1ps
module div_trial_sub
  import div_pkg::*;
(
  input  logic [DIV_W:0]   minuend_i,
  input  logic [DIV_W-1:0] subtrahend_i,
  output logic [DIV_W:0]   diff_o,
  output logic             borrow_o
);

  logic [DIV_W+1:0] full;

  // One extra bit on top catches the borrow when subtrahend > minuend.
  assign full     = {1'b0, minuend_i} - {2'b00, subtrahend_i};
  assign diff_o   = full[DIV_W:0];
  assign borrow_o = full[DIV_W+1];

endmodule

// File: rtl/seq_div_8_bit.sv
// 8-bit unsigned sequential restoring divider, one quotient bit per clock.
// Fixed 8-step RUN phase; results registered on entry to the one-cycle DONE.
// Build macro DIV_ZERO_SHORTCUT_EN: when defined, a zero divisor skips RUN
// and raises div_by_zero; when undefined, it runs the normal 8 steps
// (which naturally produce 8'hFF / dividend) and div_by_zero stays 0.
`timescale 1ns/1ps
module seq_div_8_bit
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [ITER_CNT_W-1:0] LAST_STEP = ITER_CNT_W'(DIV_W - 1);

  state_e                state_q;
  logic [ITER_CNT_W-1:0] cnt_q;
  logic [DIV_W:0]        rem_q;   // partial remainder
  logic [DIV_W-1:0]      dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [DIV_W-1:0]      dsr_q;   // captured divisor
  logic [DIV_W-1:0]      quo_q;
  logic [DIV_W-1:0]      rmd_q;
  logic                  busy_q;
  logic                  done_q;

  logic [DIV_W:0]        shifted;
  logic [DIV_W:0]        diff;
  logic                  borrow;
  logic [DIV_W:0]        rem_d;
  logic [DIV_W-1:0]      dvd_d;

  // The partial remainder is always below the divisor after a step, so its
  // top bit is dropped by the left shift; tie it off to a named sink.
  logic                  unused_rem_msb;
  assign unused_rem_msb = rem_q[DIV_W];

  assign shifted = {rem_q[DIV_W-1:0], dvd_q[DIV_W-1]};

  div_trial_sub u_trial_sub (
    .minuend_i    (shifted),
    .subtrahend_i (dsr_q),
    .diff_o       (diff),
    .borrow_o     (borrow)
  );

  // Next step values: keep the difference on no-borrow, otherwise restore.
  always_comb begin
    rem_d = borrow ? shifted : diff;
    dvd_d = {dvd_q[DIV_W-2:0], ~borrow};
  end

`ifdef DIV_ZERO_SHORTCUT_EN
  logic dbz_q;
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_SHORTCUT_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dsr_q  <= divisor;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (divisor == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rmd_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
            end
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + ITER_CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quo_q   <= dvd_d;
            rmd_q   <= rem_d[DIV_W-1:0];
`ifdef DIV_ZERO_SHORTCUT_EN
            dbz_q   <= 1'b0;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;

endmodule

// File: tb/tb_seq_div_8_bit.sv
// Self-checking bench for seq_div_8_bit: directed vector table plus
// hand-written sequences for start-while-busy, mid-run reset and
// back-to-back issue. Honours DIV_ZERO_SHORTCUT_EN for zero-divisor cases.
`timescale 1ns/1ps
module tb_seq_div_8_bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [7:0] divisor = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;

`ifdef DIV_ZERO_SHORTCUT_EN
  localparam bit SHORTCUT = 1'b1;
`else
  localparam bit SHORTCUT = 1'b0;
`endif

  seq_div_8_bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] b);
    return (SHORTCUT && b == 8'h00) ? 1 : 9;
  endfunction

  function automatic logic exp_dbz(input logic [7:0] b);
    return SHORTCUT && b == 8'h00;
  endfunction

  // Issue one division and check latency, results and return to idle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input string name);
    int lat;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'hA5; divisor = 8'h3C;
    chk({name, " busy"}, busy, 1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat(b));
    chk({name, " quotient"}, quotient, eq);
    chk({name, " remainder"}, remainder, er);
    chk({name, " dbz"}, div_by_zero, exp_dbz(b));
    @(negedge clk);
    chk({name, " done_pulse"}, done, 0);
    chk({name, " idle"}, busy, 0);
    chk({name, " hold_q"}, quotient, eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, first_lat, gap;
    logic [7:0] fq, fr;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5};
    vecs[3] = '{8'd200, 8'd200, 8'd1,   8'd0};
    vecs[4] = '{8'd42,  8'd0,   8'hFF,  8'd42};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0};
    vecs[6] = '{8'd255, 8'd255, 8'd1,   8'd0};
    vecs[7] = '{8'd254, 8'd16,  8'd15,  8'd14};
    vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1};
    vecs[9] = '{8'd0,   8'd0,   8'hFF,  8'd0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst dbz", div_by_zero, 0);
    rst_n = 1'b1;

    // Stay idle without start
    repeat (3) @(negedge clk);
    chk("idle busy", busy, 0);
    chk("idle done", done, 0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
    end

    // Start while busy is ignored; previous results held during the run
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first_lat = 0; fq = 8'h00; fr = 8'h00;
    for (int c = 4; c <= 30; c++) begin
      if (c == 5) chk("ignore hold_q", quotient, 8'hFF);
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first_lat = c; fq = quotient; fr = remainder;
        end
      end
      @(negedge clk);
    end
    chk("ignore ndone", ndone, 1);
    chk("ignore latency", first_lat, 9);
    chk("ignore quotient", fq, 14);
    chk("ignore remainder", fr, 2);

    // Reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    chk("abort no_activity", ndone, 0);
    do_op(8'd81, 8'd9, 8'd9, 8'd0, "after_abort");

    // Back-to-back: second start in the IDLE cycle right after DONE
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b first_latency", gap, 9);
    chk("b2b first_quotient", quotient, 14);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) begin
        start = 1'b1; dividend = 8'd81; divisor = 8'd9;
      end else begin
        start = 1'b0;
      end
    end while (!done && gap < 25);
    chk("b2b gap", gap, 10);
    chk("b2b quotient", quotient, 9);
    chk("b2b remainder", remainder, 0);
    @(negedge clk);
    chk("b2b done_pulse", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_div_8_bit.md
SEQ_DIV_8_BIT -- requirements
Module: seq_div_8_bit

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits (DIV_W from package).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 dividend  input  8  unsigned dividend, captured when start is accepted.
REQ-006 divisor  input  8  unsigned divisor, captured when start is accepted.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 quotient  output  8  unsigned quotient, registered.
REQ-010 remainder  output  8  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  registered flag, qualified by done.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE (DONE lasts exactly one cycle).
REQ-013 IDLE with start=1 at an edge SHALL capture operands, clear partial remainder (9 bits), load iteration count 0 and enter RUN.
REQ-014 IDLE with start=0 SHALL stay in IDLE.
REQ-015 Start SHALL be ignored in RUN and DONE; captured operands SHALL be unaffected.
REQ-016 Each RUN edge SHALL do one restoring step: shift {rem,dividend MSB} left; trial-subtract the divisor; if no borrow, keep the difference and shift in quotient bit 1; else restore and shift in 0.
REQ-017 After the 8th RUN step the FSM SHALL enter DONE and load quotient/remainder; done=1 in DONE; next edge returns to IDLE.
REQ-018 Latency SHALL be fixed: done is high in the 9th cycle after the edge that accepted start (RUN occupies cycles 1-8).
REQ-019 quotient, remainder and div_by_zero SHALL change only on entry to DONE and hold until the next DONE.
REQ-020 Divisor 0 SHALL yield quotient=8'hFF and remainder=dividend in all configurations.
REQ-021 Back-to-back: start is honoured in the IDLE cycle immediately following DONE (minimum 10-cycle issue interval).

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal count/partial remainder=0.
REQ-023 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; after release the block SHALL accept a fresh start.

Configuration
REQ-024 Macro DIV_ZERO_SHORTCUT_EN SHALL control divide-by-zero handling.
REQ-025 Defined: divisor 0 at start SHALL skip RUN (IDLE->DONE); done is high in the 1st cycle after acceptance, with div_by_zero=1 and REQ-020 values.
REQ-026 Undefined: divisor 0 SHALL run the normal 8 steps (latency per REQ-018); div_by_zero SHALL be constant 0 and the port retained.
REQ-027 For non-zero divisors, behaviour SHALL be identical in both configurations.

Structure
REQ-028 Package div_pkg SHALL hold DIV_W=8, ITER_CNT_W=4 and the state enum type (IDLE, RUN, DONE).
REQ-029 One sub-module div_trial_sub (9-bit minus 8-bit, returning difference and borrow-out) SHALL implement the trial subtraction; everything else stays in seq_div_8_bit.

Verification
REQ-030 dividend=100, divisor=7, start pulse -> busy next cycle; done 9 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0.
REQ-031 255/1 -> quotient=255, remainder=0; 5/9 -> quotient=0, remainder=5; 200/200 -> quotient=1, remainder=0.
REQ-032 dividend=42, divisor=0 -> quotient=8'hFF, remainder=42; with DIV_ZERO_SHORTCUT_EN, done after 1 cycle and div_by_zero=1; without it, done after 9 cycles and div_by_zero=0.
REQ-033 Start 100/7, then start 50/5 pulsed on RUN cycle 3 -> single done with quotient=14, remainder=2; no second done.
REQ-034 Start 100/7, rst_n low on RUN cycle 4 -> all outputs 0 immediately, no done; after release, 81/9 -> quotient=9, remainder=0.
REQ-035 Start 100/7, then 81/9 in the IDLE cycle right after done -> second done exactly 10 cycles after the first, with quotient=9, remainder=0.
